fifo_burst_reader: RTL and testbench
====================================

# fifo_burst_reader

Read-side stage placed directly downstream of the team's show-ahead FIFO. It drains the FIFO through its `rdreq`/`q`/`empty`/`usedw` interface and re-emits the data as framed bursts on a valid/ready stream with start-of-packet and end-of-packet markers. A 2-entry skid buffer keeps `fifo_rdreq_o` free of any combinational path from `ready_i`. An optional idle timeout flushes partial bursts.

## Interface
- `DWIDTH`, 32: data word width; matches the FIFO.
- `AWIDTH`, 4: FIFO address width; `fifo_usedw_i` is `AWIDTH+1` bits.
- `BURST_LEN`, 8: words per full burst; legal range 1..2**AWIDTH.
- `TIMEOUT`, 64: idle cycles before a partial burst is flushed; must be ≥1. Used only with the timeout macro.
- `clk_i`  in  1  clock; all logic on posedge.
- `srst_i`  in  1  reset; synchronous, active-high.
- `fifo_q_i`  in  DWIDTH  FIFO head word; valid while `!fifo_empty_i` (show-ahead).
- `fifo_empty_i`  in  1  FIFO empty flag.
- `fifo_usedw_i`  in  AWIDTH+1  FIFO occupancy.
- `fifo_rdreq_o`  out  1  pop request; one word per asserted cycle.
- `data_o`  out  DWIDTH  stream data.
- `valid_o`  out  1  stream valid.
- `ready_i`  in  1  stream ready; a transfer happens when `valid_o && ready_i`.
- `sop_o`  out  1  first word of a burst; qualified by `valid_o`.
- `eop_o`  out  1  last word of a burst; qualified by `valid_o`.
- `burst_len_o`  out  AWIDTH+1  length of the current burst; stable from the sop word through the eop word.
- `burst_cnt_o`  out  16  count of completed bursts (eop transfers); wraps at 2**16.

## Operation
- FSM states: IDLE, BURST.
- In IDLE, enter BURST when `fifo_usedw_i >= BURST_LEN`.
  - Latch `len = BURST_LEN`.
  - Clear `pop_left` to `len` and `out_left` to `len`.
- In BURST:
  - `fifo_rdreq_o = pop_left != 0 && !fifo_empty_i && skid_free`, where `skid_free` means the skid buffer holds fewer than 2 words after accounting for this cycle's output transfer, using registered state only.
  - Each pop decrements `pop_left`.
  - Return to IDLE on the cycle `pop_left` goes 1→0.
  - Words already in the skid buffer keep draining independently.
- Framing:
  - `sop_o` is set on the word with `out_left == len`.
  - `eop_o` is set on the word with `out_left == 1`.
  - `out_left` decrements on each output transfer.
  - The framing counters for a burst are carried with the words in the skid buffer, so the next burst may begin popping before the previous eop has left.
- Data ordering is strict FIFO order. No word is dropped or duplicated under any `ready_i` pattern.
- While `valid_o && !ready_i`, hold `data_o`, `sop_o`, `eop_o` and `burst_len_o` stable.
- `burst_cnt_o` increments on every transfer with `eop_o`.
- Words written to the FIFO during a burst do not extend that burst.
- Reset values:
  - `fifo_rdreq_o` = 0, `valid_o` = 0, `sop_o` = 0, `eop_o` = 0.
  - `data_o` = 0, `burst_len_o` = 0, `burst_cnt_o` = 0.
  - State = IDLE; skid buffer empty; timer = 0.
- Reset mid-burst: words held in the skid buffer are discarded and any partial burst is abandoned. FIFO contents are the FIFO's own concern.

## Timing
- Start condition sampled in IDLE at cycle N → BURST at N+1 → first `fifo_rdreq_o` at N+1 at the earliest.
- A word popped at cycle M is presented on `data_o` at M+1 at the earliest.
- With `ready_i` held high, throughput is 1 word/cycle within a burst.
- There is at least 1 cycle with `fifo_rdreq_o` = 0 between the last pop of one burst and the first pop of the next (the IDLE cycle).
- The output path is fully registered.
- `fifo_rdreq_o` depends only on registered state and `fifo_empty_i`.

## Configuration
- `FIFO_BURST_READER_TIMEOUT_EN` defined:
  - In IDLE, an idle timer counts cycles with `!fifo_empty_i && fifo_usedw_i < BURST_LEN`.
  - The timer clears when the FIFO is empty or when a burst starts.
  - When the timer reaches `TIMEOUT`, enter BURST with `len = fifo_usedw_i`, which is a partial burst.
  - A full-burst condition takes priority over the timeout.
- Undefined:
  - No timer logic is built.
  - Only full `BURST_LEN` bursts are issued.
  - Fewer than `BURST_LEN` words remain in the FIFO indefinitely.

## Test plan
- Write 8 words 0x10..0x17, `ready_i` = 1 → one burst of 0x10..0x17 on 8 consecutive cycles; sop on 0x10, eop on 0x17, `burst_len_o` = 8, `burst_cnt_o` = 1.
- Write 16 words, `ready_i` = 1 → two bursts of 8 in order; at least 1 idle pop cycle between them; `burst_cnt_o` = 2.
- Write 8 words, `ready_i` random with 50% duty → identical data and framing to the first scenario; outputs held stable during stall cycles; at most 2 words outstanding beyond the output transfers.
- With timeout enabled and `TIMEOUT` = 64: write 3 words and wait → a burst of length 3 starts 64 cycles after the FIFO went non-empty, with sop on word 0 and eop on word 2. Without the macro: no output after 200 cycles.
- Assert `srst_i` for 1 cycle after the 4th word of a burst is output → outputs return to reset values the next cycle; `burst_cnt_o` = 0; state returns to IDLE.
- `BURST_LEN` = 1, write 4 words → 4 bursts, each with sop and eop both set on its single word; `burst_cnt_o` = 4.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// Drains a show-ahead FIFO in framed bursts onto a valid/ready stream via a 2-entry skid buffer.
// Optional idle-timeout flush of partial bursts: define FIFO_BURST_READER_TIMEOUT_EN.
module fifo_burst_reader #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 4,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  input  logic [AWIDTH:0]   fifo_usedw_i,
  output logic              fifo_rdreq_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              sop_o,
  output logic              eop_o,
  output logic [AWIDTH:0]   burst_len_o,
  output logic [15:0]       burst_cnt_o
);

  localparam logic [AWIDTH:0] BURST_LEN_C = (AWIDTH+1)'(BURST_LEN);
  localparam logic [AWIDTH:0] ONE_C       = (AWIDTH+1)'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t              state_r, state_s;
  logic [AWIDTH:0]     len_r, len_s;
  logic [AWIDTH:0]     pop_left_r, pop_left_s;
  logic                full_start_s;
  logic                timeout_s;
  logic                pop_s;
  logic                load_s;
  logic                in_sop_s;
  logic                in_eop_s;

  logic [DWIDTH-1:0]   spare_data_r;
  logic                spare_sop_r;
  logic                spare_eop_r;
  logic [AWIDTH:0]     spare_len_r;
  logic                spare_valid_r;

  assign full_start_s = (fifo_usedw_i >= BURST_LEN_C);

`ifdef FIFO_BURST_READER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST_C = TW'(TIMEOUT - 1);

  logic [TW-1:0] timer_r, timer_s;
  logic          counting_s;

  assign counting_s = (state_r == IDLE) && !fifo_empty_i && !full_start_s;
  assign timeout_s  = counting_s && (timer_r == TIMEOUT_LAST_C);

  // Idle timer: counts partial-occupancy cycles, clears on empty or burst start.
  always_comb begin
    timer_s = '0;
    if (counting_s && !timeout_s) begin
      timer_s = timer_r + TW'(1);
    end else begin
      timer_s = '0;
    end
  end

  // Idle timer register.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      timer_r <= '0;
    end else begin
      timer_r <= timer_s;
    end
  end
`else
  assign timeout_s = 1'b0 && (TIMEOUT < 1);
`endif

  // Skid is free only when the spare slot is empty; keeps rdreq off the ready path.
  assign pop_s        = (state_r == BURST) && (pop_left_r != '0) && !fifo_empty_i && !spare_valid_r;
  assign fifo_rdreq_o = pop_s;
  assign in_sop_s     = (pop_left_r == len_r);
  assign in_eop_s     = (pop_left_r == ONE_C);
  assign load_s       = !valid_o || ready_i;

  // Next-state and burst counters.
  always_comb begin
    state_s    = state_r;
    len_s      = len_r;
    pop_left_s = pop_left_r;
    case (state_r)
      IDLE: begin
        if (full_start_s) begin
          state_s    = BURST;
          len_s      = BURST_LEN_C;
          pop_left_s = BURST_LEN_C;
        end else if (timeout_s) begin
          state_s    = BURST;
          len_s      = fifo_usedw_i;
          pop_left_s = fifo_usedw_i;
        end else begin
          state_s    = IDLE;
        end
      end
      BURST: begin
        if (pop_s) begin
          pop_left_s = pop_left_r - ONE_C;
          if (pop_left_r == ONE_C) begin
            state_s = IDLE;
          end else begin
            state_s = BURST;
          end
        end else begin
          state_s = BURST;
        end
      end
      default: begin
        state_s    = IDLE;
        len_s      = '0;
        pop_left_s = '0;
      end
    endcase
  end

  // State and burst counter registers.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_r    <= IDLE;
      len_r      <= '0;
      pop_left_r <= '0;
    end else begin
      state_r    <= state_s;
      len_r      <= len_s;
      pop_left_r <= pop_left_s;
    end
  end

  // Output register plus spare slot; framing tags travel with each word.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      data_o        <= '0;
      valid_o       <= 1'b0;
      sop_o         <= 1'b0;
      eop_o         <= 1'b0;
      burst_len_o   <= '0;
      spare_data_r  <= '0;
      spare_sop_r   <= 1'b0;
      spare_eop_r   <= 1'b0;
      spare_len_r   <= '0;
      spare_valid_r <= 1'b0;
      burst_cnt_o   <= 16'd0;
    end else begin
      if (load_s) begin
        if (spare_valid_r) begin
          data_o      <= spare_data_r;
          sop_o       <= spare_sop_r;
          eop_o       <= spare_eop_r;
          burst_len_o <= spare_len_r;
          valid_o     <= 1'b1;
        end else if (pop_s) begin
          data_o      <= fifo_q_i;
          sop_o       <= in_sop_s;
          eop_o       <= in_eop_s;
          burst_len_o <= len_r;
          valid_o     <= 1'b1;
        end else begin
          sop_o       <= 1'b0;
          eop_o       <= 1'b0;
          valid_o     <= 1'b0;
        end
      end
      // pop_s implies the spare is empty, so the two branches never collide.
      if (load_s && spare_valid_r) begin
        spare_valid_r <= 1'b0;
      end else if (!load_s && pop_s) begin
        spare_data_r  <= fifo_q_i;
        spare_sop_r   <= in_sop_s;
        spare_eop_r   <= in_eop_s;
        spare_len_r   <= len_r;
        spare_valid_r <= 1'b1;
      end
      if (valid_o && ready_i && eop_o) begin
        burst_cnt_o <= burst_cnt_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: queue-based FIFO model and burst-framing scoreboard.
module tb_fifo_burst_reader;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int BL = 8;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          srst;
  logic [DW-1:0] fifo_q;
  logic          fifo_empty;
  logic [AW:0]   fifo_usedw;
  logic          fifo_rdreq;
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
  logic          sop;
  logic          eop;
  logic [AW:0]   burst_len;
  logic [15:0]   burst_cnt;

  logic [DW-1:0] q1;
  logic          empty1;
  logic [AW:0]   usedw1;
  logic          rdreq1;
  logic [DW-1:0] data1;
  logic          valid1;
  logic          ready1;
  logic          sop1;
  logic          eop1;
  logic [AW:0]   len1;
  logic [15:0]   cnt1;

  always #5 clk = ~clk;

  fifo_burst_reader #(.DWIDTH(DW), .AWIDTH(AW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk_i(clk), .srst_i(srst), .fifo_q_i(fifo_q), .fifo_empty_i(fifo_empty),
    .fifo_usedw_i(fifo_usedw), .fifo_rdreq_o(fifo_rdreq), .data_o(data), .valid_o(valid),
    .ready_i(ready), .sop_o(sop), .eop_o(eop), .burst_len_o(burst_len), .burst_cnt_o(burst_cnt)
  );

  fifo_burst_reader #(.DWIDTH(DW), .AWIDTH(AW), .BURST_LEN(1), .TIMEOUT(TO)) dut1 (
    .clk_i(clk), .srst_i(srst), .fifo_q_i(q1), .fifo_empty_i(empty1),
    .fifo_usedw_i(usedw1), .fifo_rdreq_o(rdreq1), .data_o(data1), .valid_o(valid1),
    .ready_i(ready1), .sop_o(sop1), .eop_o(eop1), .burst_len_o(len1), .burst_cnt_o(cnt1)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [AW:0]   len;
  } beat_t;

  logic [DW-1:0] fifo_m[$];
  beat_t         exp_q[$];
  int n_tests = 0, n_fail = 0;
  int cyc = 0, pops = 0, xfers = 0, pushed_idx = 0, exp_cnt = 0;
  int first_xfer_cyc = -1, last_xfer_cyc = -1, first_pop_cyc = -1;
  bit mon_en = 1'b0, rnd_ready = 1'b0, prev_stall = 1'b0, prev_rd = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_sop, prev_eop;
  logic [AW:0]   prev_len;

  task automatic drive_fifo();
    fifo_empty = (fifo_m.size() == 0);
    fifo_usedw = (AW+1)'(fifo_m.size());
    fifo_q     = fifo_empty ? '0 : fifo_m[0];
  endtask

  task automatic push_tagged(input logic [DW-1:0] w, input logic s, input logic e, input int l);
    beat_t b;
    b.data = w; b.sop = s; b.eop = e; b.len = (AW+1)'(l);
    fifo_m.push_back(w);
    exp_q.push_back(b);
    drive_fifo();
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    push_tagged(w, (pushed_idx % BL) == 0, (pushed_idx % BL) == BL - 1, BL);
    pushed_idx++;
  endtask

  task automatic tick();
    bit    rd;
    int    outst;
    beat_t b;
    @(negedge clk);
    rd = fifo_rdreq;
    if (mon_en) begin
      if (prev_stall) begin
        n_tests++;
        if ({valid, data, sop, eop, burst_len} !== {1'b1, prev_data, prev_sop, prev_eop, prev_len}) begin
          n_fail++;
          $display("FAIL hold cyc %0d: got %h/%b/%b/%0d exp %h/%b/%b/%0d", cyc, data, sop, eop,
                   burst_len, prev_data, prev_sop, prev_eop, prev_len);
        end
      end
      outst = pops - xfers;
      n_tests++;
      if (outst < 0 || outst > 2) begin
        n_fail++;
        $display("FAIL outstanding cyc %0d: got %0d exp 0..2", cyc, outst);
      end
      if (rd) begin
        n_tests++;
        if (prev_rd && pops > 0 && (pops % BL) == 0) begin
          n_fail++;
          $display("FAIL gap cyc %0d: got back-to-back pop after burst end exp idle cycle", cyc);
        end
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
      end
      if (valid && ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected cyc %0d: got word %h exp none", cyc, data);
        end else begin
          b = exp_q.pop_front();
          if ({data, sop, eop, burst_len} !== {b.data, b.sop, b.eop, b.len}) begin
            n_fail++;
            $display("FAIL beat cyc %0d: got %h/%b/%b/%0d exp %h/%b/%b/%0d", cyc, data, sop, eop,
                     burst_len, b.data, b.sop, b.eop, b.len);
          end
          if (b.eop) exp_cnt++;
        end
        if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
        xfers++;
      end
    end
    prev_stall = valid && !ready;
    prev_rd    = rd;
    prev_data  = data;
    prev_sop   = sop;
    prev_eop   = eop;
    prev_len   = burst_len;
    @(posedge clk);
    #1;
    cyc++;
    if (mon_en) begin
      n_tests++;
      if (burst_cnt !== 16'(exp_cnt)) begin
        n_fail++;
        $display("FAIL burst_cnt cyc %0d: got %0d exp %0d", cyc, burst_cnt, exp_cnt);
      end
    end
    if (rd) begin
      if (fifo_m.size() > 0) void'(fifo_m.pop_front());
      pops++;
    end
    ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    drive_fifo();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || pops != xfers) && n < budget) begin
      tick();
      n++;
    end
    n_tests++;
    if (exp_q.size() != 0 || pops != xfers) begin
      n_fail++;
      $display("FAIL drain: got %0d words left exp 0 within %0d cycles", exp_q.size(), budget);
    end
  endtask

  task automatic test_reset();
    srst = 1'b1; ready = 1'b1; ready1 = 1'b1;
    drive_fifo();
    empty1 = 1'b1; usedw1 = '0; q1 = '0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({fifo_rdreq, valid, sop, eop, data, burst_len, burst_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset: got rd%b v%b s%b e%b d%h l%0d c%0d exp all 0", fifo_rdreq, valid, sop,
               eop, data, burst_len, burst_cnt);
    end
    srst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_single_burst();
    rnd_ready = 1'b0;
    first_xfer_cyc = -1;
    for (int i = 0; i < 8; i++) push_word(32'h10 + i);
    drain(60);
    n_tests++;
    if (last_xfer_cyc - first_xfer_cyc != BL - 1) begin
      n_fail++;
      $display("FAIL throughput: got span %0d exp %0d", last_xfer_cyc - first_xfer_cyc, BL - 1);
    end
    n_tests++;
    if (burst_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL single_cnt: got %0d exp 1", burst_cnt);
    end
  endtask

  task automatic test_two_bursts();
    for (int i = 0; i < 16; i++) push_word($urandom);
    drain(100);
    n_tests++;
    if (burst_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL two_cnt: got %0d exp 3", burst_cnt);
    end
  endtask

  task automatic test_random_ready();
    rnd_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(32'h10 + i);
    drain(300);
    rnd_ready = 1'b0;
    ready = 1'b1;
    n_tests++;
    if (burst_cnt !== 16'd4) begin
      n_fail++;
      $display("FAIL random_cnt: got %0d exp 4", burst_cnt);
    end
  endtask

  task automatic test_partial();
    int p0, x0, c0;
    p0 = pops; x0 = xfers;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    first_pop_cyc = -1;
    for (int i = 0; i < 3; i++) push_tagged(32'hA0 + i, i == 0, i == 2, 3);
    c0 = cyc;
    drain(TO + 60);
    n_tests++;
    if (first_pop_cyc != c0 + TO) begin
      n_fail++;
      $display("FAIL timeout_start: got cyc %0d exp %0d", first_pop_cyc, c0 + TO);
    end
    pushed_idx = 0; pops = 0; xfers = 0;
`else
    for (int i = 0; i < 3; i++) push_word(32'hA0 + i);
    c0 = cyc;
    repeat (200) tick();
    n_tests++;
    if (pops != p0 || xfers != x0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL no_output: got %0d pops %0d xfers after %0d cycles exp 0", pops - p0,
               xfers - x0, cyc - c0);
    end
`endif
  endtask

  task automatic test_reset_mid_burst();
    int x0, n;
    x0 = xfers; n = 0;
    for (int i = 0; i < 8; i++) push_word($urandom);
    while (xfers - x0 < 4 && n < 60) begin
      tick();
      n++;
    end
    mon_en = 1'b0;
    srst = 1'b1;
    tick();
    srst = 1'b0;
    n_tests++;
    if ({valid, sop, eop, data, burst_len, burst_cnt} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got v%b s%b e%b d%h l%0d c%0d exp all 0", valid, sop, eop, data,
               burst_len, burst_cnt);
    end
    n_tests++;
    if (fifo_empty !== 1'b0 || fifo_rdreq !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_idle: got rdreq %b empty %b exp rdreq 0 with data waiting",
               fifo_rdreq, fifo_empty);
    end
    fifo_m.delete(); exp_q.delete();
    drive_fifo();
    pushed_idx = 0; exp_cnt = 0; pops = 0; xfers = 0;
    prev_stall = 1'b0; prev_rd = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) push_word($urandom);
    drain(60);
    n_tests++;
    if (burst_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL after_reset_cnt: got %0d exp 1", burst_cnt);
    end
  endtask

  task automatic test_burst_len_one();
    logic [DW-1:0] f1[$];
    logic [DW-1:0] e1[$];
    logic [DW-1:0] w;
    bit rd, prd;
    int k;
    k = 0; prd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      f1.push_back(w);
      e1.push_back(w);
    end
    empty1 = 1'b0; usedw1 = (AW+1)'(f1.size()); q1 = f1[0];
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      rd = rdreq1;
      if (rd) begin
        n_tests++;
        if (prd) begin
          n_fail++;
          $display("FAIL bl1_gap cyc %0d: got consecutive pops exp idle between", c);
        end
      end
      if (valid1) begin
        n_tests++;
        if (e1.size() == 0) begin
          n_fail++;
          $display("FAIL bl1_extra: got word %h exp none", data1);
        end else begin
          w = e1.pop_front();
          if ({data1, sop1, eop1, len1} !== {w, 1'b1, 1'b1, 5'd1}) begin
            n_fail++;
            $display("FAIL bl1_beat: got %h/%b/%b/%0d exp %h/1/1/1", data1, sop1, eop1, len1, w);
          end
          k++;
        end
      end
      prd = rd;
      @(posedge clk);
      #1;
      if (rd && f1.size() > 0) void'(f1.pop_front());
      empty1 = (f1.size() == 0);
      usedw1 = (AW+1)'(f1.size());
      q1 = empty1 ? '0 : f1[0];
    end
    n_tests++;
    if (k != 4 || cnt1 !== 16'd4) begin
      n_fail++;
      $display("FAIL bl1_count: got %0d words cnt %0d exp 4 words cnt 4", k, cnt1);
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_two_bursts();
    test_random_ready();
    test_partial();
    test_reset_mid_burst();
    test_burst_len_one();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
